// File: rtl/banked_rom.sv
// Multi-bank read-only memory with a req/ready/valid read handshake and
// programmable wait states; banks at or above NUM_BANKS return FILL_DATA and err.
module banked_rom #(
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_LOG2  = 10,
  parameter int                BANK_BITS   = 2,
  parameter int                NUM_BANKS   = 2,
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] FILL_DATA   = '0,
  parameter string             BANK0_HEX   = "./software/bios.hex",
  parameter string             BANK1_HEX   = "./software/charset.hex",
  parameter string             BANK2_HEX   = "",
  parameter string             BANK3_HEX   = "",
  localparam int               ADDR_W      = BANK_BITS + DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [3:0] WS_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [BANK_BITS-1:0]  bank_sel_q;
  logic [DATA_W-1:0]     bank_dout [NUM_BANKS];
  logic [DATA_W-1:0]     rdata_mux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      bank_sel_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      // Bank select is captured together with the bank output registers so
      // the mux stays aligned with the data through wait states and back-to-back.
      if (state_q == S_READ) begin
        bank_sel_q <= addr_q[ADDR_W-1:DEPTH_LOG2];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (WAIT_STATES == 0) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = WS_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (req) begin
          addr_d  = addr;
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] dout_q;

    initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else if (state_q == S_READ) begin
        dout_q <= mem[addr_q[DEPTH_LOG2-1:0]];
      end
    end

    assign bank_dout[b] = dout_q;
  end

  always_comb begin
    rdata_mux = FILL_DATA;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bank_sel_q == BANK_BITS'(i)) rdata_mux = bank_dout[i];
    end
  end

  assign ready = (state_q == S_IDLE) || (state_q == S_RESP);
  assign valid = (state_q == S_RESP);
  assign rdata = rdata_mux;
  assign err   = ({1'b0, bank_sel_q} >= (BANK_BITS + 1)'(NUM_BANKS));

endmodule

// File: tb/tb_banked_rom.sv
// Directed bench for banked_rom: one instance with no wait states, one with three.
module tb_banked_rom;

  localparam logic [31:0] FILL = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req3 = 1'b0;
  logic [11:0] addr0 = '0, addr3 = '0;
  logic        ready0, valid0, err0, ready3, valid3, err3;
  logic [31:0] rdata0, rdata3;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  banked_rom #(.WAIT_STATES(0), .FILL_DATA(FILL), .BANK0_HEX(""), .BANK1_HEX("")) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .addr(addr0),
    .ready(ready0), .valid(valid0), .rdata(rdata0), .err(err0));

  banked_rom #(.WAIT_STATES(3), .FILL_DATA(FILL), .BANK0_HEX(""), .BANK1_HEX("")) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .addr(addr3),
    .ready(ready3), .valid(valid3), .rdata(rdata3), .err(err3));

  function automatic logic [31:0] word(input logic [11:0] a);
    if (a[11:10] == 2'd0) return 32'hB105_0000 + {22'd0, a[9:0]};
    if (a[11:10] == 2'd1) return 32'hC4A2_0000 + {22'd0, a[9:0]};
    return FILL;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete read; sel=0 targets the zero-wait instance, sel=1 the 3-wait one.
  task automatic do_read(input int sel, input logic [11:0] a,
                         input logic [31:0] exp_d, input logic exp_e, input int ws);
    int k, nrdy;
    logic v, r;
    logic [31:0] held;
    if (sel == 0) begin req0 = 1'b1; addr0 = a; end
    else          begin req3 = 1'b1; addr3 = a; end
    step();
    if (sel == 0) begin req0 = 1'b0; addr0 = 12'h000; end
    else          begin req3 = 1'b0; addr3 = 12'h000; end
    k = 0;
    nrdy = 0;
    v = (sel == 0) ? valid0 : valid3;
    while (!v && k < 40) begin
      r = (sel == 0) ? ready0 : ready3;
      if (!r) nrdy++;
      step();
      k++;
      v = (sel == 0) ? valid0 : valid3;
    end
    chk($sformatf("latency[%h]", a), k, 1 + ws);
    chk($sformatf("ready_low[%h]", a), nrdy, 1 + ws);
    chk($sformatf("rdata[%h]", a), (sel == 0) ? rdata0 : rdata3, exp_d);
    chk($sformatf("err[%h]", a), {31'd0, (sel == 0) ? err0 : err3}, {31'd0, exp_e});
    held = (sel == 0) ? rdata0 : rdata3;
    step();
    chk($sformatf("valid_drop[%h]", a), {31'd0, (sel == 0) ? valid0 : valid3}, 32'd0);
    chk($sformatf("rdata_hold[%h]", a), (sel == 0) ? rdata0 : rdata3, held);
  endtask

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
    logic        e;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{12'h005, 32'hB105_0005, 1'b0};
    vecs[1] = '{12'h405, 32'hC4A2_0005, 1'b0};
    vecs[2] = '{12'hC10, FILL,          1'b1};
    vecs[3] = '{12'h010, 32'hB105_0010, 1'b0};
    vecs[4] = '{12'h7FF, 32'hC4A2_03FF, 1'b0};
    vecs[5] = '{12'h800, FILL,          1'b1};
    vecs[6] = '{12'h3FF, 32'hB105_03FF, 1'b0};
    vecs[7] = '{12'h000, 32'hB105_0000, 1'b0};

    #1;
    for (int i = 0; i < 1024; i++) begin
      dut0.g_bank[0].mem[i] = 32'hB105_0000 + i;
      dut0.g_bank[1].mem[i] = 32'hC4A2_0000 + i;
      dut3.g_bank[0].mem[i] = 32'hB105_0000 + i;
      dut3.g_bank[1].mem[i] = 32'hC4A2_0000 + i;
    end

    // Reset held with a pending request
    req0 = 1'b1;
    addr0 = 12'h005;
    step();
    step();
    chk("rst_valid", {31'd0, valid0}, 32'd0);
    chk("rst_rdata", rdata0, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    req0 = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rst_ready", {31'd0, ready0}, 32'd1);
    chk("rst_ready3", {31'd0, ready3}, 32'd1);

    foreach (vecs[i]) do_read(0, vecs[i].a, vecs[i].d, vecs[i].e, 0);

    do_read(1, 12'h005, 32'hB105_0005, 1'b0, 3);
    do_read(1, 12'hC10, FILL, 1'b1, 3);
    do_read(1, 12'h402, 32'hC4A2_0002, 1'b0, 3);

    // Back-to-back with req held high over addresses 0,1,2
    req0 = 1'b1;
    addr0 = 12'h000;
    step();
    for (int s = 0; s < 7; s++) begin
      chk($sformatf("b2b_valid[%0d]", s), {31'd0, valid0}, {31'd0, s[0]});
      if (s[0]) chk($sformatf("b2b_rdata[%0d]", s), rdata0, word(12'(s / 2)));
      if (s == 0) addr0 = 12'h001;
      if (s == 2) addr0 = 12'h002;
      if (s == 4) req0 = 1'b0;
      step();
    end

    // Reset pulse during WAIT aborts the access
    req3 = 1'b1;
    addr3 = 12'h406;
    step();
    req3 = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_rdata", rdata3, 32'd0);
    for (int s = 0; s < 2; s++) begin
      step();
      chk($sformatf("abort_rst_valid[%0d]", s), {31'd0, valid3}, 32'd0);
    end
    rst_n = 1'b1;
    for (int s = 0; s < 6; s++) begin
      step();
      chk($sformatf("abort_valid[%0d]", s), {31'd0, valid3}, 32'd0);
      chk($sformatf("abort_ready[%0d]", s), {31'd0, ready3}, 32'd1);
    end
    do_read(1, 12'h7FF, 32'hC4A2_03FF, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
